// File: rtl/mem_arbiter_pkg.sv
// Shared widths, memory access sizes/codes, arbiter state encodings and port IDs.
// Pipeline stages import this to decode the arbiter owner field.
package mem_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 3;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE          = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    MEM_PORT_D = 1'b0,
    MEM_PORT_F = 1'b1
  } mem_port_e;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = '{
    addr:    '0,
    wr_data: '0,
    wr_en:   1'b0,
    count:   MEM_COUNT_NONE
  };

  // Fetches are always full-word reads with no write payload.
  function automatic mem_req_t fetch_req(input logic [ADDR_W-1:0] addr);
    mem_req_t r;
    r         = MEM_REQ_IDLE;
    r.addr    = addr;
    r.count   = MEM_COUNT_WORD;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Grant selection between load/store (D) and fetch (F) with a starvation guard
// that hands F the grant after STARVE_LIMIT consecutive D wins while F waits.
module mem_arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       d_valid_i,
  input  logic       f_valid_i,
  input  logic       d_accept_i,
  input  logic       f_accept_i,
  input  arb_state_e state_i,
  output logic       grant_d_o,
  output logic       grant_f_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             open_win;

  assign open_win = (state_i == ARB_IDLE) || (state_i == ARB_RESP);

  always_comb begin
    grant_d_o = 1'b0;
    grant_f_o = 1'b0;
    if (open_win) begin
      if (d_valid_i && f_valid_i) begin
        if (starve_cnt_q == CNT_LIMIT) grant_f_o = 1'b1;
        else                           grant_d_o = 1'b1;
      end else if (d_valid_i) begin
        grant_d_o = 1'b1;
      end else if (f_valid_i) begin
        grant_f_o = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (f_accept_i) begin
      starve_cnt_d = '0;
    end else if (d_accept_i && f_valid_i) begin
      if (starve_cnt_q != CNT_LIMIT) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else if (open_win && !f_valid_i) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one registered-response memory between fetch (F) and load/store (D).
//   state     | meaning
//   ARB_IDLE  | no transaction in flight, accepting
//   ARB_ISSUE | request driven on o_mem_req_*, memory samples at end of cycle
//   ARB_RESP  | memory response routed to owner, next request may be accepted
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_d_req_valid,
  output logic                   o_d_req_ready,
  input  logic [ADDR_W-1:0]      i_d_req_addr,
  input  logic [WORD_W-1:0]      i_d_req_wr_data,
  input  logic                   i_d_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_d_req_count,
  output logic                   o_d_res_valid,
  output logic [WORD_W-1:0]      o_d_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_d_res_code,
  input  logic                   i_f_req_valid,
  output logic                   o_f_req_ready,
  input  logic [ADDR_W-1:0]      i_f_req_addr,
  output logic                   o_f_res_valid,
  output logic [WORD_W-1:0]      o_f_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_f_res_code,
  output logic [ADDR_W-1:0]      o_mem_req_addr,
  output logic [WORD_W-1:0]      o_mem_req_wr_data,
  output logic                   o_mem_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_mem_req_count,
  input  logic [WORD_W-1:0]      i_mem_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_mem_res_code
);

  arb_state_e state_q, state_d;
  mem_port_e  owner_q, owner_d;
  mem_req_t   mem_req_q, mem_req_d;
  logic       grant_d, grant_f;
  logic       d_accept, f_accept, accept;

  mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clk       (clk),
    .aresetn   (aresetn),
    .d_valid_i (i_d_req_valid),
    .f_valid_i (i_f_req_valid),
    .d_accept_i(d_accept),
    .f_accept_i(f_accept),
    .state_i   (state_q),
    .grant_d_o (grant_d),
    .grant_f_o (grant_f)
  );

  // Reset forces the ready lines low even though the grant path is combinational.
  assign o_d_req_ready = grant_d & aresetn;
  assign o_f_req_ready = grant_f & aresetn;
  assign d_accept      = i_d_req_valid & o_d_req_ready;
  assign f_accept      = i_f_req_valid & o_f_req_ready;
  assign accept        = d_accept | f_accept;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (accept) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  state_d = accept ? ARB_ISSUE : ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_d_res_valid   = 1'b0;
    o_d_res_rd_data = '0;
    o_d_res_code    = MEM_CODE_NONE;
    o_f_res_valid   = 1'b0;
    o_f_res_rd_data = '0;
    o_f_res_code    = MEM_CODE_NONE;
    if (state_q == ARB_RESP) begin
      if (owner_q == MEM_PORT_D) begin
        o_d_res_valid   = 1'b1;
        o_d_res_rd_data = i_mem_res_rd_data;
        o_d_res_code    = i_mem_res_code;
      end else begin
        o_f_res_valid   = 1'b1;
        o_f_res_rd_data = i_mem_res_rd_data;
        o_f_res_code    = i_mem_res_code;
      end
    end
  end

  // Request register is non-idle only in the cycle after an accept, i.e. in ARB_ISSUE.
  always_comb begin
    mem_req_d = MEM_REQ_IDLE;
    owner_d   = owner_q;
    if (d_accept) begin
      mem_req_d.addr    = i_d_req_addr;
      mem_req_d.wr_data = i_d_req_wr_data;
      mem_req_d.wr_en   = i_d_req_wr_en;
      mem_req_d.count   = i_d_req_count;
      owner_d           = MEM_PORT_D;
    end else if (f_accept) begin
      mem_req_d = fetch_req(i_f_req_addr);
      owner_d   = MEM_PORT_F;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_req_q <= MEM_REQ_IDLE;
      owner_q   <= MEM_PORT_D;
    end else begin
      mem_req_q <= mem_req_d;
      owner_q   <= owner_d;
    end
  end

  assign o_mem_req_addr    = mem_req_q.addr;
  assign o_mem_req_wr_data = mem_req_q.wr_data;
  assign o_mem_req_wr_en   = mem_req_q.wr_en;
  assign o_mem_req_count   = mem_req_q.count;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 256-byte registered-response memory plus directed and
// randomized scenarios checked against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic                   clk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   i_d_req_valid = 1'b0;
  logic                   o_d_req_ready;
  logic [ADDR_W-1:0]      i_d_req_addr = '0;
  logic [WORD_W-1:0]      i_d_req_wr_data = '0;
  logic                   i_d_req_wr_en = 1'b0;
  logic [MEM_COUNT_W-1:0] i_d_req_count = MEM_COUNT_NONE;
  logic                   o_d_res_valid;
  logic [WORD_W-1:0]      o_d_res_rd_data;
  logic [MEM_CODE_W-1:0]  o_d_res_code;
  logic                   i_f_req_valid = 1'b0;
  logic                   o_f_req_ready;
  logic [ADDR_W-1:0]      i_f_req_addr = '0;
  logic                   o_f_res_valid;
  logic [WORD_W-1:0]      o_f_res_rd_data;
  logic [MEM_CODE_W-1:0]  o_f_res_code;
  logic [ADDR_W-1:0]      o_mem_req_addr;
  logic [WORD_W-1:0]      o_mem_req_wr_data;
  logic                   o_mem_req_wr_en;
  logic [MEM_COUNT_W-1:0] o_mem_req_count;
  logic [WORD_W-1:0]      mem_rd_q;
  logic [MEM_CODE_W-1:0]  mem_code_q;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_env [256];
  logic [7:0] mem_ref [256];

  typedef struct {
    int         due;
    bit         port_f;
    logic [31:0] data;
    logic [2:0]  code;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .i_d_req_valid    (i_d_req_valid),
    .o_d_req_ready    (o_d_req_ready),
    .i_d_req_addr     (i_d_req_addr),
    .i_d_req_wr_data  (i_d_req_wr_data),
    .i_d_req_wr_en    (i_d_req_wr_en),
    .i_d_req_count    (i_d_req_count),
    .o_d_res_valid    (o_d_res_valid),
    .o_d_res_rd_data  (o_d_res_rd_data),
    .o_d_res_code     (o_d_res_code),
    .i_f_req_valid    (i_f_req_valid),
    .o_f_req_ready    (o_f_req_ready),
    .i_f_req_addr     (i_f_req_addr),
    .o_f_res_valid    (o_f_res_valid),
    .o_f_res_rd_data  (o_f_res_rd_data),
    .o_f_res_code     (o_f_res_code),
    .o_mem_req_addr   (o_mem_req_addr),
    .o_mem_req_wr_data(o_mem_req_wr_data),
    .o_mem_req_wr_en  (o_mem_req_wr_en),
    .o_mem_req_count  (o_mem_req_count),
    .i_mem_res_rd_data(mem_rd_q),
    .i_mem_res_code   (mem_code_q)
  );

  function automatic logic [2:0] calc_code(input logic [31:0] a, input logic [2:0] c, input logic w);
    int ai, ci;
    if (c != 3'd1 && c != 3'd2 && c != 3'd4) return MEM_CODE_INVALID;
    ai = int'(a[15:0]);
    ci = int'(c);
    if ((ai % ci) != 0) return MEM_CODE_MISALIGNED;
    if (a[31:16] != 16'd0 || ai + ci > 256) return MEM_CODE_OUT_OF_BOUNDS;
    return w ? MEM_CODE_WRITE : MEM_CODE_READ;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] r = '0;
    for (int k = 0; k < int'(c); k++) r[8*k +: 8] = mem_env[8'(a + 32'(k))];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] r = '0;
    for (int k = 0; k < int'(c); k++) r[8*k +: 8] = mem_ref[8'(a + 32'(k))];
    return r;
  endfunction

  // Memory contents return to a known pattern on every reset.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_rd_q   <= '0;
      mem_code_q <= MEM_CODE_NONE;
      for (int k = 0; k < 256; k++) mem_env[k] <= 8'(k * 37 + 1);
      mem_env[8'h10] <= 8'hEF;
      mem_env[8'h11] <= 8'hBE;
      mem_env[8'h12] <= 8'hAD;
      mem_env[8'h13] <= 8'hDE;
    end else if (o_mem_req_count != MEM_COUNT_NONE) begin
      mem_code_q <= calc_code(o_mem_req_addr, o_mem_req_count, o_mem_req_wr_en);
      if (calc_code(o_mem_req_addr, o_mem_req_count, o_mem_req_wr_en) == MEM_CODE_READ)
        mem_rd_q <= env_rd(o_mem_req_addr, o_mem_req_count);
      else
        mem_rd_q <= '0;
      if (calc_code(o_mem_req_addr, o_mem_req_count, o_mem_req_wr_en) == MEM_CODE_WRITE)
        for (int k = 0; k < 4; k++)
          if (k < int'(o_mem_req_count)) mem_env[8'(o_mem_req_addr + 32'(k))] <= o_mem_req_wr_data[8*k +: 8];
    end else begin
      mem_rd_q   <= '0;
      mem_code_q <= MEM_CODE_NONE;
    end
  end

  task automatic ref_reset();
    for (int k = 0; k < 256; k++) mem_ref[k] = 8'(k * 37 + 1);
    mem_ref[8'h10] = 8'hEF;
    mem_ref[8'h11] = 8'hBE;
    mem_ref[8'h12] = 8'hAD;
    mem_ref[8'h13] = 8'hDE;
  endtask

  task automatic idle_inputs();
    i_d_req_valid = 1'b0;
    i_f_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    ref_reset();
    aresetn = 1'b0;
    i_d_req_valid = 1'b1;
    i_f_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (o_d_req_ready !== 1'b0 || o_f_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready d=%b f=%b want 0 0", o_d_req_ready, o_f_req_ready);
    end
    total++;
    if (o_mem_req_count !== MEM_COUNT_NONE || o_mem_req_addr !== '0 || o_mem_req_wr_en !== 1'b0 || o_mem_req_wr_data !== '0) begin
      bad++; $display("FAIL reset_mem count=%0d addr=%h we=%b wd=%h want all 0", o_mem_req_count, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data);
    end
    total++;
    if (o_d_res_valid !== 1'b0 || o_f_res_valid !== 1'b0 || o_d_res_rd_data !== '0 || o_f_res_rd_data !== '0 ||
        o_d_res_code !== '0 || o_f_res_code !== '0) begin
      bad++; $display("FAIL reset_res dv=%b fv=%b dd=%h fd=%h want zeros", o_d_res_valid, o_f_res_valid, o_d_res_rd_data, o_f_res_rd_data);
    end
    idle_inputs();
    #2 aresetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_f_read();
    @(posedge clk); #1;
    i_f_req_valid = 1'b1;
    i_f_req_addr  = 32'h10;
    @(negedge clk);
    total++;
    if (o_f_req_ready !== 1'b1 || o_d_req_ready !== 1'b0) begin
      bad++; $display("FAIL fread_ready f=%b d=%b want 1 0", o_f_req_ready, o_d_req_ready);
    end
    @(posedge clk); #1;
    i_f_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_mem_req_count !== MEM_COUNT_WORD || o_mem_req_addr !== 32'h10 || o_mem_req_wr_en !== 1'b0 || o_mem_req_wr_data !== '0) begin
      bad++; $display("FAIL fread_issue count=%0d addr=%h we=%b want 4 10 0", o_mem_req_count, o_mem_req_addr, o_mem_req_wr_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (o_f_res_valid !== 1'b1 || o_f_res_rd_data !== 32'hDEADBEEF || o_f_res_code !== MEM_CODE_READ || o_d_res_valid !== 1'b0) begin
      bad++; $display("FAIL fread_resp v=%b data=%h code=%0d dv=%b want 1 deadbeef 1 0", o_f_res_valid, o_f_res_rd_data, o_f_res_code, o_d_res_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (o_f_res_valid !== 1'b0 || o_mem_req_count !== MEM_COUNT_NONE) begin
      bad++; $display("FAIL fread_after v=%b count=%0d want 0 0", o_f_res_valid, o_mem_req_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    i_d_req_valid = 1'b1; i_d_req_addr = 32'h21; i_d_req_wr_data = 32'h0000_00AB;
    i_d_req_wr_en = 1'b1; i_d_req_count = MEM_COUNT_BYTE;
    @(negedge clk);
    total++;
    if (o_d_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready got=%b want 1", o_d_req_ready); end
    mem_ref[8'h21] = 8'hAB;
    exp_rd = ref_rd(32'h20, MEM_COUNT_WORD);
    @(posedge clk); #1;
    i_d_req_addr = 32'h20; i_d_req_wr_data = 32'h0; i_d_req_wr_en = 1'b0; i_d_req_count = MEM_COUNT_WORD;
    @(negedge clk);
    total++;
    if (o_d_req_ready !== 1'b0 || o_mem_req_count !== MEM_COUNT_BYTE || o_mem_req_addr !== 32'h21 || o_mem_req_wr_en !== 1'b1) begin
      bad++; $display("FAIL b2b_issue ready=%b count=%0d addr=%h we=%b want 0 1 21 1", o_d_req_ready, o_mem_req_count, o_mem_req_addr, o_mem_req_wr_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (o_d_res_valid !== 1'b1 || o_d_res_code !== MEM_CODE_WRITE || o_d_req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_wr_resp v=%b code=%0d ready=%b want 1 2 1", o_d_res_valid, o_d_res_code, o_d_req_ready);
    end
    @(posedge clk); #1;
    i_d_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_mem_req_count !== MEM_COUNT_WORD || o_mem_req_addr !== 32'h20 || o_d_res_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_rd_issue count=%0d addr=%h v=%b want 4 20 0", o_mem_req_count, o_mem_req_addr, o_d_res_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (o_d_res_valid !== 1'b1 || o_d_res_code !== MEM_CODE_READ || o_d_res_rd_data[15:8] !== 8'hAB || o_d_res_rd_data !== exp_rd) begin
      bad++; $display("FAIL b2b_rd_resp v=%b code=%0d data=%h want 1 1 %h", o_d_res_valid, o_d_res_code, o_d_res_rd_data, exp_rd);
    end
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit got[$];
    bit want[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int cycles = 0;
    @(posedge clk); #1;
    i_d_req_valid = 1'b1; i_d_req_addr = 32'h44; i_d_req_wr_en = 1'b0; i_d_req_count = MEM_COUNT_WORD;
    i_f_req_valid = 1'b1; i_f_req_addr = 32'h40;
    while (got.size() < 10 && cycles < 40) begin
      @(negedge clk);
      if (o_d_req_ready === 1'b1) got.push_back(1'b0);
      if (o_f_req_ready === 1'b1) got.push_back(1'b1);
      cycles++;
      @(posedge clk); #1;
    end
    idle_inputs();
    total++;
    if (got.size() < 10) begin
      bad++; $display("FAIL starve_timeout grants=%0d want 10", got.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        total++;
        if (got[k] !== want[k]) begin
          bad++; $display("FAIL starve_order idx=%0d got_f=%b want_f=%b", k, got[k], want[k]);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    i_d_req_valid = 1'b1; i_d_req_addr = 32'h3; i_d_req_wr_en = 1'b0; i_d_req_count = MEM_COUNT_HALF;
    @(negedge clk);
    total++;
    if (o_d_req_ready !== 1'b1) begin bad++; $display("FAIL mis_ready got=%b want 1", o_d_req_ready); end
    @(posedge clk); #1;
    i_d_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (o_d_res_valid !== 1'b1 || o_d_res_code !== MEM_CODE_MISALIGNED || o_d_res_rd_data !== '0 ||
        o_f_res_valid !== 1'b0 || o_f_res_code !== '0 || o_f_res_rd_data !== '0) begin
      bad++; $display("FAIL mis_resp v=%b code=%0d data=%h fv=%b want 1 3 0 0", o_d_res_valid, o_d_res_code, o_d_res_rd_data, o_f_res_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    @(posedge clk); #1;
    i_d_req_valid = 1'b1; i_d_req_addr = 32'h10; i_d_req_wr_en = 1'b0; i_d_req_count = MEM_COUNT_WORD;
    @(posedge clk); #1;
    i_d_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_mem_req_count !== MEM_COUNT_WORD) begin bad++; $display("FAIL rmid_issue count=%0d want 4", o_mem_req_count); end
    aresetn = 1'b0;
    ref_reset();
    #1;
    total++;
    if (o_mem_req_count !== MEM_COUNT_NONE || o_mem_req_addr !== '0) begin
      bad++; $display("FAIL rmid_async count=%0d addr=%h want 0 0", o_mem_req_count, o_mem_req_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) #2 aresetn = 1'b1;
      if (o_d_res_valid !== 1'b0 || o_f_res_valid !== 1'b0) strobes++;
    end
    total++;
    if (strobes != 0) begin bad++; $display("FAIL rmid_strobe count=%0d want 0", strobes); end
    @(posedge clk); #1;
    i_f_req_valid = 1'b1; i_f_req_addr = 32'h10;
    @(posedge clk); #1;
    i_f_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (o_f_res_valid !== 1'b1 || o_f_res_rd_data !== 32'hDEADBEEF || o_f_res_code !== MEM_CODE_READ) begin
      bad++; $display("FAIL rmid_after v=%b data=%h code=%0d want 1 deadbeef 1", o_f_res_valid, o_f_res_rd_data, o_f_res_code);
    end
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int     n = 400;
    int     last_acc = -10;
    int     starve = 0;
    bit     d_pend = 0, f_pend = 0;
    bit     open, exp_d, exp_f, dv, fv;
    exp_t   e;
    logic [2:0] c;
    logic [2:0] cnts[4] = '{3'd1, 3'd2, 3'd4, 3'd4};
    for (int i = 0; i < n + 4; i++) begin
      @(posedge clk); #1;
      if (i < n && !d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1;
        i_d_req_count   = ($urandom_range(0, 11) == 0) ? 3'd3 : cnts[$urandom_range(0, 3)];
        i_d_req_addr    = ($urandom_range(0, 9) == 0) ? 32'h100 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) i_d_req_addr = i_d_req_addr & ~32'(i_d_req_count - 3'd1);
        i_d_req_wr_en   = 1'($urandom_range(0, 1));
        i_d_req_wr_data = $urandom;
      end
      if (i < n && !f_pend && $urandom_range(0, 2) != 0) begin
        f_pend = 1;
        i_f_req_addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 4) != 0) i_f_req_addr = i_f_req_addr & ~32'h3;
      end
      i_d_req_valid = d_pend;
      i_f_req_valid = f_pend;
      dv = d_pend; fv = f_pend;
      @(negedge clk);
      open  = (i != last_acc + 1);
      exp_d = 0; exp_f = 0;
      if (open) begin
        if (dv && fv) begin
          if (starve >= LIMIT) exp_f = 1; else exp_d = 1;
        end else if (dv) exp_d = 1;
        else if (fv) exp_f = 1;
      end
      total++;
      if (o_d_req_ready !== exp_d || o_f_req_ready !== exp_f) begin
        bad++; $display("FAIL rnd_ready i=%0d d=%b f=%b want %b %b", i, o_d_req_ready, o_f_req_ready, exp_d, exp_f);
      end
      total++;
      if (exp_q.size() > 0 && exp_q[0].due == i) begin
        e = exp_q.pop_front();
        if (e.port_f ? (o_f_res_valid !== 1'b1 || o_d_res_valid !== 1'b0 || o_f_res_rd_data !== e.data || o_f_res_code !== e.code)
                     : (o_d_res_valid !== 1'b1 || o_f_res_valid !== 1'b0 || o_d_res_rd_data !== e.data || o_d_res_code !== e.code)) begin
          bad++; $display("FAIL rnd_resp i=%0d port_f=%b dv=%b fv=%b dd=%h fd=%h dc=%0d fc=%0d want data=%h code=%0d",
                          i, e.port_f, o_d_res_valid, o_f_res_valid, o_d_res_rd_data, o_f_res_rd_data, o_d_res_code, o_f_res_code, e.data, e.code);
        end
      end else if (o_d_res_valid !== 1'b0 || o_f_res_valid !== 1'b0) begin
        bad++; $display("FAIL rnd_spurious i=%0d dv=%b fv=%b want 0 0", i, o_d_res_valid, o_f_res_valid);
      end
      if (exp_f) starve = 0;
      else if (exp_d && fv) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else if (open && !fv) starve = 0;
      if (exp_d || exp_f) begin
        last_acc = i;
        e.due    = i + 2;
        e.port_f = exp_f;
        if (exp_d) begin
          c = calc_code(i_d_req_addr, i_d_req_count, i_d_req_wr_en);
          e.data = (c == MEM_CODE_READ) ? ref_rd(i_d_req_addr, i_d_req_count) : 32'h0;
          if (c == MEM_CODE_WRITE)
            for (int k = 0; k < int'(i_d_req_count); k++) mem_ref[8'(i_d_req_addr + 32'(k))] = i_d_req_wr_data[8*k +: 8];
          d_pend = 0;
        end else begin
          c = calc_code(i_f_req_addr, MEM_COUNT_WORD, 1'b0);
          e.data = (c == MEM_CODE_READ) ? ref_rd(i_f_req_addr, MEM_COUNT_WORD) : 32'h0;
          f_pend = 0;
        end
        e.code = c;
        exp_q.push_back(e);
      end
    end
    idle_inputs();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_f_read();
    test_back_to_back();
    test_starvation();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single simulation memory between instruction fetch (port F) and the load/store stage (port D). It accepts requests over valid/ready handshakes and drives one registered request per transaction into the memory. It routes the memory's registered response and code back to the port that owns the transaction. D has priority, and a starvation guard bounds how long F can wait.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive D grants while F is waiting; must be ≥1.
- `clk`  in  1  clock, rising edge
- `aresetn`  in  1  reset, asynchronous, active-low
- `i_d_req_valid`  in  1  D request present
- `o_d_req_ready`  out  1  D request accepted this cycle
- `i_d_req_addr`  in  `ADDR_W`  D byte address
- `i_d_req_wr_data`  in  `WORD_W`  D write data
- `i_d_req_wr_en`  in  1  D write (1) / read (0)
- `i_d_req_count`  in  `MEM_COUNT_W`  D access size
- `o_d_res_valid`  out  1  D response strobe
- `o_d_res_rd_data`  out  `WORD_W`  D read data
- `o_d_res_code`  out  `MEM_CODE_W`  D response code
- `i_f_req_valid`  in  1  F request present; always a word read
- `o_f_req_ready`  out  1  F request accepted this cycle
- `i_f_req_addr`  in  `ADDR_W`  F byte address
- `o_f_res_valid`  out  1  F response strobe
- `o_f_res_rd_data`  out  `WORD_W`  F instruction word
- `o_f_res_code`  out  `MEM_CODE_W`  F response code
- `o_mem_req_addr`  out  `ADDR_W`  memory request address, registered
- `o_mem_req_wr_data`  out  `WORD_W`  memory write data, registered
- `o_mem_req_wr_en`  out  1  memory write enable, registered
- `o_mem_req_count`  out  `MEM_COUNT_W`  memory access size, registered
- `i_mem_res_rd_data`  in  `WORD_W`  memory read data
- `i_mem_res_code`  in  `MEM_CODE_W`  memory response code

## Operation
- **FSM states:** IDLE, ISSUE, RESP. A 1-bit `owner` register records the port that owns the in-flight transaction (D or F).
- **Grant rule** (combinational):
  - Only D valid: D wins.
  - Only F valid: F wins.
  - Both valid: D wins unless `starve_cnt == STARVE_LIMIT`, in which case F wins.
- **Ready:** `o_x_req_ready` is asserted only for the winning port, and only in IDLE or RESP. Ready is never asserted in ISSUE.
- **Acceptance:** a request is accepted when valid and ready are both high. On the next edge:
  - the request is latched onto `o_mem_req_*`;
  - `owner` is set to the accepted port;
  - the FSM goes to ISSUE.
- **F requests** are issued with count `MEM_COUNT_WORD` and `wr_en` = 0. Write data is 0.
- **ISSUE** lasts exactly one cycle, then the FSM goes to RESP. The memory samples the request at the end of ISSUE.
- **Memory outputs outside ISSUE:** addr, wr_data and wr_en are 0, and count is `MEM_COUNT_NONE`.
- **RESP:**
  - `o_<owner>_res_valid` = 1; `res_rd_data` and `res_code` are passed through combinationally from `i_mem_res_*`, including `MEM_CODE_MISALIGNED`, `MEM_CODE_OUT_OF_BOUNDS` and `MEM_CODE_INVALID`, unmodified.
  - The non-owner port has valid = 0, data = 0 and code = 0.
  - If a new request is accepted in the same cycle, the next state is ISSUE; otherwise it is IDLE.
- **Starvation counter** (`starve_cnt`, width `$clog2(STARVE_LIMIT+1)`):
  - increments, saturating at `STARVE_LIMIT`, when D is accepted while `i_f_req_valid` is high;
  - clears when F is accepted, or on any cycle in IDLE/RESP where `i_f_req_valid` is low;
  - holds otherwise.
- **Request stability:** the requester must hold its request stable until accepted. The arbiter captures it only at the acceptance edge.

## Timing
- **Reset:**
  - state IDLE, `owner` = D, `starve_cnt` = 0;
  - all `o_mem_req_*` are 0 and count is `MEM_COUNT_NONE`;
  - both ready outputs are 0 during reset;
  - all `res_valid`, `res_rd_data` and `res_code` outputs are 0.
- **Latency:** a request accepted in cycle A produces memory count ≠ NONE in cycle A+1 and a response strobe in cycle A+2.
- **Throughput:** one transaction per 2 cycles. Back-to-back operation works by accepting the next request during RESP.
- **Reset mid-transaction:** the transaction is dropped, no response strobe is emitted, and the memory count returns to NONE asynchronously.
- **Valid deasserted before acceptance:** no effect; nothing is issued.

## Structure
- Access-size and response-code constants come from the shared `mem_codes.vh`; widths come from `config.vh`.
- FSM state encodings and the port IDs (`MEM_PORT_D`, `MEM_PORT_F`) go in a new shared header, `mem_arb.vh`, so that pipeline stages can decode `owner`.
- One sub-module, `mem_arb_priority`, holds the grant logic and the starvation counter. It takes the two valids, the accept strobes and the FSM state, and outputs the grant.

## Test plan
- F only, read at 0x10 of preloaded 0xDEADBEEF → `o_f_req_ready` in A; `o_mem_req_count` = WORD in A+1; `o_f_res_valid` = 1 with 0xDEADBEEF and `MEM_CODE_READ` in A+2.
- D byte write 0xAB at 0x21, then D word read at 0x20 → `MEM_CODE_WRITE` is returned, followed by a read whose data has 0xAB in bits 15:8. The second request is accepted in the first response cycle.
- D and F held valid continuously with `STARVE_LIMIT` = 4 → grant order D, D, D, D, F, D, D, D, D, F.
- D halfword read at 0x3 → `o_d_res_code` = `MEM_CODE_MISALIGNED` and data 0; F sees no strobe.
- `aresetn` pulsed low in ISSUE → no response on either port, outputs return to reset values, and the next request completes normally.
